// File: rtl/tile_pkg.sv
// Shared types and defaults for the brute-force solver tiles and their sequencer.
// The grid edge length comes from the GRID_LEN macro; a 4x4 grid is assumed if
// the build does not define it.
`ifndef GRID_LEN
`define GRID_LEN 4
`endif

package tile_pkg;

  // Sequencer control states: one token holder at a time, two terminal states.
  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT,
    DONE,
    FAIL
  } seq_fsm_state;

  // Per-tile search states, shared with the tile instances.
  typedef enum logic [1:0] {
    TILE_IDLE,
    TILE_ADVANCE,
    TILE_TEST,
    TILE_PASS
  } tile_fsm_state;

  localparam int NUM_TILES_DEFAULT = `GRID_LEN * `GRID_LEN;

endpackage

// File: rtl/seq_proto_check.sv
// Combinational protocol-violation detector for the tile sequencer.
// Flags pass pulses from a tile that does not hold the token, any pass pulse
// outside WAIT, and a simultaneous forward+backtrack from the token holder.
module seq_proto_check
  import tile_pkg::*;
#(
  parameter int NUM_TILES = NUM_TILES_DEFAULT,
  parameter int IDX_W     = $clog2(NUM_TILES)
) (
  input  seq_fsm_state         state,
  input  logic [IDX_W-1:0]     cur_idx,
  input  logic [NUM_TILES-1:0] passfwd,
  input  logic [NUM_TILES-1:0] passbak,
  output logic                 err_now
);

  localparam logic [NUM_TILES-1:0] ONE = {{(NUM_TILES-1){1'b0}}, 1'b1};

  // Evaluate all three violation classes against the current token holder.
  always_comb begin
    logic [NUM_TILES-1:0] holder;
    logic [NUM_TILES-1:0] any_pass;
    logic                 foreign;
    logic                 off_wait;
    logic                 both;
    holder   = ONE << cur_idx;
    any_pass = passfwd | passbak;
    foreign  = |(any_pass & ~holder);
    off_wait = (|any_pass) && (state != WAIT);
    both     = (state == WAIT) && passfwd[cur_idx] && passbak[cur_idx];
    err_now  = foreign | off_wait | both;
  end

endmodule

// File: rtl/tile_sequencer.sv
// Token controller for the brute-force solver: grants exactly one tile at a
// time, advances on passfwd, retreats on passbak, and reports solved/unsolvable
// at the two ends of the tile array.
// Optional macro TILE_SEQUENCER_STATS_EN adds saturating grant/backtrack counters.
module tile_sequencer
  import tile_pkg::*;
#(
  parameter int NUM_TILES = NUM_TILES_DEFAULT,
  parameter int IDX_W     = $clog2(NUM_TILES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic [NUM_TILES-1:0] myturn,
  input  logic [NUM_TILES-1:0] passfwd,
  input  logic [NUM_TILES-1:0] passbak,
  output logic [IDX_W-1:0]     cur_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 failed,
  output logic                 proto_err
`ifdef TILE_SEQUENCER_STATS_EN
  ,
  output logic [31:0]          grant_count,
  output logic [31:0]          backtrack_count
`endif
);

  localparam logic [NUM_TILES-1:0] ONE      = {{(NUM_TILES-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_TILES - 1);

  seq_fsm_state     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             start_ok;
  logic             restart_clr;
  logic             err_now;
  logic             proto_err_q;

  seq_proto_check #(
    .NUM_TILES (NUM_TILES),
    .IDX_W     (IDX_W)
  ) u_proto_check (
    .state   (state_q),
    .cur_idx (idx_q),
    .passfwd (passfwd),
    .passbak (passbak),
    .err_now (err_now)
  );

  // Next-state and next-index selection; backtrack wins over a simultaneous forward.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d  = state_q;
    idx_d    = idx_q;
    start_ok = 1'b0;
    unique case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          start_ok = 1'b1;
          idx_d    = '0;
          state_d  = GRANT;
        end
      end
      GRANT: state_d = WAIT;
      WAIT: begin
        if (passbak[idx_q]) begin
          if (idx_q == '0) begin
            state_d = FAIL;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = GRANT;
          end
        end else if (passfwd[idx_q]) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = GRANT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A restart from a terminal state also wipes the recorded protocol error.
  assign restart_clr = start_ok && ((state_q == DONE) || (state_q == FAIL));

  // State, token index and sticky protocol-error registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      idx_q       <= idx_d;
      proto_err_q <= err_now | (proto_err_q & ~restart_clr);
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    myturn    = (state_q == GRANT) ? (ONE << idx_q) : '0;
    cur_idx   = idx_q;
    busy      = (state_q == GRANT) || (state_q == WAIT);
    done      = (state_q == DONE);
    failed    = (state_q == FAIL);
    proto_err = proto_err_q;
  end

`ifdef TILE_SEQUENCER_STATS_EN
  logic bak_move;

  assign bak_move = (state_q == WAIT) && passbak[idx_q] && (idx_q != '0);

  // Saturating activity counters, cleared whenever a solve is (re)started.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_count     <= '0;
      backtrack_count <= '0;
    end else if (start_ok) begin
      grant_count     <= '0;
      backtrack_count <= '0;
    end else begin
      if ((state_q == GRANT) && (grant_count != '1)) begin
        grant_count <= grant_count + 32'd1;
      end
      if (bak_move && (backtrack_count != '1)) begin
        backtrack_count <= backtrack_count + 32'd1;
      end
    end
  end
`endif

endmodule
